// File: rtl/stream_min_max.sv
`default_nettype none
// ============================================================================
// Module  : stream_min_max (with helper comparator_lt)
// Brief   : Streaming signed min/max reducer, one result per frame over
//           valid/ready. Define STREAM_MINMAX_INDEX_EN to add min/max indices.
// Revision: 1.0 - initial release
// ============================================================================

module comparator_lt #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         lt
);
    assign lt = $signed(a) < $signed(b);
endmodule

module stream_min_max #(
    parameter int N         = 32,
    parameter int FRAME_LEN = 8,
    parameter int CNT_W     = $clog2(FRAME_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_min,
    output logic [N-1:0]     out_max,
`ifdef STREAM_MINMAX_INDEX_EN
    output logic [CNT_W-1:0] out_count,
    output logic [CNT_W-1:0] out_min_idx,
    output logic [CNT_W-1:0] out_max_idx
`else
    output logic [CNT_W-1:0] out_count
`endif
);

    localparam logic [CNT_W-1:0] C_FRAME_LEN = CNT_W'(FRAME_LEN);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [N-1:0]     min_q, min_d;
    logic [N-1:0]     max_q, max_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] count_inc;
    logic             lt_min;
    logic             lt_max;

    comparator_lt #(.N(N)) u_lt_min (
        .a  (in_data),
        .b  (min_q),
        .lt (lt_min)
    );

    comparator_lt #(.N(N)) u_lt_max (
        .a  (max_q),
        .b  (in_data),
        .lt (lt_max)
    );

    assign count_inc = count_q + CNT_W'(1);

`ifdef STREAM_MINMAX_INDEX_EN
    logic [CNT_W-1:0] min_idx_q, min_idx_d;
    logic [CNT_W-1:0] max_idx_q, max_idx_d;
`endif

    always_comb begin
        state_d = state_q;
        min_d   = min_q;
        max_d   = max_q;
        count_d = count_q;
`ifdef STREAM_MINMAX_INDEX_EN
        min_idx_d = min_idx_q;
        max_idx_d = max_idx_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    min_d   = in_data;
                    max_d   = in_data;
                    count_d = CNT_W'(1);
`ifdef STREAM_MINMAX_INDEX_EN
                    min_idx_d = '0;
                    max_idx_d = '0;
`endif
                    state_d = (in_last || FRAME_LEN == 1) ? ST_DONE : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (in_valid) begin
                    // Strict compares so ties keep the earliest sample
                    if (lt_min) begin
                        min_d = in_data;
`ifdef STREAM_MINMAX_INDEX_EN
                        min_idx_d = count_q;
`endif
                    end
                    if (lt_max) begin
                        max_d = in_data;
`ifdef STREAM_MINMAX_INDEX_EN
                        max_idx_d = count_q;
`endif
                    end
                    count_d = count_inc;
                    if (in_last || count_inc == C_FRAME_LEN) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            min_q   <= '0;
            max_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            min_q   <= min_d;
            max_q   <= max_d;
            count_q <= count_d;
        end
    end

`ifdef STREAM_MINMAX_INDEX_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            min_idx_q <= '0;
            max_idx_q <= '0;
        end else begin
            min_idx_q <= min_idx_d;
            max_idx_q <= max_idx_d;
        end
    end

    assign out_min_idx = min_idx_q;
    assign out_max_idx = max_idx_q;
`endif

    // Handshake flags come from state alone: no combinational path from inputs
    assign in_ready  = (state_q != ST_DONE);
    assign out_valid = (state_q == ST_DONE);
    assign out_min   = min_q;
    assign out_max   = max_q;
    assign out_count = count_q;

endmodule

`default_nettype wire
